// File: rtl/udma_hyper_cfg_bank.sv
// HyperBus configuration bank: double-buffered per-device timing registers,
// idle-gated commit and transaction-ID allocation for the uDMA cfg bus.

module udma_hyper_cfg_bank_regs #(
  parameter int DELAY_BIT_WIDTH = 3,
  parameter int DEST_SIZE       = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr_en,
  input  logic                       apply,
  input  logic [4:0]                 off,
  input  logic [31:0]                wr_data,
  output logic [31:0]                rd_data,
  output logic [2:0]                 page_bound,
  output logic [4:0]                 t_lat,
  output logic                       en_lat,
  output logic [31:0]                t_cs_max,
  output logic [31:0]                t_rw_rec,
  output logic [DELAY_BIT_WIDTH-1:0] rwds_dly,
  output logic [3:0]                 t_vari,
  output logic [1:0]                 mem_sel,
  output logic [DEST_SIZE-1:0]       rx_dest,
  output logic [DEST_SIZE-1:0]       tx_dest
);

  typedef struct packed {
    logic [2:0]                 page_bound;
    logic [4:0]                 t_lat;
    logic                       en_lat;
    logic [31:0]                t_cs_max;
    logic [31:0]                t_rw_rec;
    logic [DELAY_BIT_WIDTH-1:0] rwds_dly;
    logic [3:0]                 t_vari;
    logic [1:0]                 mem_sel;
    logic [DEST_SIZE-1:0]       rx_dest;
    logic [DEST_SIZE-1:0]       tx_dest;
  } regs_t;

  localparam regs_t RST = '{
    page_bound: 3'd0,
    t_lat:      5'd6,
    en_lat:     1'b1,
    t_cs_max:   32'd665,
    t_rw_rec:   32'd6,
    rwds_dly:   DELAY_BIT_WIDTH'(2),
    t_vari:     4'd3,
    mem_sel:    2'd0,
    rx_dest:    '0,
    tx_dest:    '0
  };

  regs_t shadow, shadow_n, active;

  always_comb begin
    shadow_n = shadow;
    if (wr_en) begin
      case (off)
        5'h00: shadow_n.page_bound = wr_data[2:0];
        5'h01: shadow_n.t_lat      = wr_data[4:0];
        5'h02: shadow_n.en_lat     = wr_data[0];
        5'h03: shadow_n.t_cs_max   = wr_data;
        5'h04: shadow_n.t_rw_rec   = wr_data;
        5'h05: shadow_n.rwds_dly   = wr_data[DELAY_BIT_WIDTH-1:0];
        5'h06: shadow_n.t_vari     = wr_data[3:0];
        5'h08: shadow_n.mem_sel    = wr_data[1:0];
        5'h0A: begin
          shadow_n.rx_dest = wr_data[DEST_SIZE-1:0];
          shadow_n.tx_dest = wr_data[8 +: DEST_SIZE];
        end
        default: ;
      endcase
    end
  end

  // active samples the pre-edge shadow, so a same-cycle write lands in shadow only
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow <= RST;
      active <= RST;
    end else begin
      shadow <= shadow_n;
      if (apply) active <= shadow;
    end
  end

  always_comb begin
    rd_data = '0;
    case (off)
      5'h00: rd_data[2:0]                 = shadow.page_bound;
      5'h01: rd_data[4:0]                 = shadow.t_lat;
      5'h02: rd_data[0]                   = shadow.en_lat;
      5'h03: rd_data                      = shadow.t_cs_max;
      5'h04: rd_data                      = shadow.t_rw_rec;
      5'h05: rd_data[DELAY_BIT_WIDTH-1:0] = shadow.rwds_dly;
      5'h06: rd_data[3:0]                 = shadow.t_vari;
      5'h08: rd_data[1:0]                 = shadow.mem_sel;
      5'h0A: begin
        rd_data[DEST_SIZE-1:0]  = shadow.rx_dest;
        rd_data[8 +: DEST_SIZE] = shadow.tx_dest;
      end
      default: ;
    endcase
  end

  assign page_bound = active.page_bound;
  assign t_lat      = active.t_lat;
  assign en_lat     = active.en_lat;
  assign t_cs_max   = active.t_cs_max;
  assign t_rw_rec   = active.t_rw_rec;
  assign rwds_dly   = active.rwds_dly;
  assign t_vari     = active.t_vari;
  assign mem_sel    = active.mem_sel;
  assign rx_dest    = active.rx_dest;
  assign tx_dest    = active.tx_dest;

endmodule

module udma_hyper_cfg_bank #(
  parameter int NB_DEV          = 2,
  parameter int NB_CH           = 8,
  parameter int DELAY_BIT_WIDTH = 3,
  // tracks udma_pkg::DEST_SIZE of the surrounding uDMA
  parameter int DEST_SIZE       = 5,
  localparam int BANK_W = (NB_DEV > 1) ? $clog2(NB_DEV) : 1,
  localparam int ID_W   = (NB_CH > 1) ? $clog2(NB_CH) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [31:0]                       cfg_data_i,
  input  logic [5+BANK_W-1:0]               cfg_addr_i,
  input  logic                              cfg_valid_i,
  input  logic                              cfg_reg_rwn_i,
  output logic [31:0]                       cfg_data_o,
  output logic                              cfg_ready_o,
  output logic [NB_DEV*3-1:0]               cfg_page_bound_o,
  output logic [NB_DEV*5-1:0]               cfg_t_latency_access_o,
  output logic [NB_DEV-1:0]                 cfg_en_latency_additional_o,
  output logic [NB_DEV*32-1:0]              cfg_t_cs_max_o,
  output logic [NB_DEV*32-1:0]              cfg_t_read_write_recovery_o,
  output logic [NB_DEV*DELAY_BIT_WIDTH-1:0] cfg_t_rwds_delay_line_o,
  output logic [NB_DEV*4-1:0]               cfg_t_variable_latency_check_o,
  output logic [NB_DEV*2-1:0]               cfg_mem_sel_o,
  output logic [NB_DEV*DEST_SIZE-1:0]       cfg_rx_dest_o,
  output logic [NB_DEV*DEST_SIZE-1:0]       cfg_tx_dest_o,
  input  logic [NB_CH-1:0]                  busy_vec_i,
  output logic                              commit_pending_o,
  output logic                              commit_done_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_IDLE, ST_APPLY} state_t;

  logic [4:0]               off;
  logic [BANK_W-1:0]        bank;
  logic                     bank_ok, wr, rd, apply;
  logic [NB_DEV-1:0]        bank_we;
  logic [NB_DEV-1:0][31:0]  bank_rd;
  logic [NB_CH-1:0]         reserved, busy_q, free, set_vec, rel_vec;
  logic [ID_W-1:0]          alloc_id;
  logic                     alloc_valid;
  state_t                   state, state_n;

  assign off         = cfg_addr_i[4:0];
  assign bank        = cfg_addr_i[5 +: BANK_W];
  assign bank_ok     = 32'(bank) < NB_DEV;
  assign wr          = cfg_valid_i & ~cfg_reg_rwn_i;
  assign rd          = cfg_valid_i & cfg_reg_rwn_i;
  assign cfg_ready_o = 1'b1;

  for (genvar g = 0; g < NB_DEV; g++) begin : g_bank
    assign bank_we[g] = wr & bank_ok & (bank == BANK_W'(g));

    udma_hyper_cfg_bank_regs #(
      .DELAY_BIT_WIDTH (DELAY_BIT_WIDTH),
      .DEST_SIZE       (DEST_SIZE)
    ) u_regs (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .wr_en      (bank_we[g]),
      .apply      (apply),
      .off        (off),
      .wr_data    (cfg_data_i),
      .rd_data    (bank_rd[g]),
      .page_bound (cfg_page_bound_o[g*3 +: 3]),
      .t_lat      (cfg_t_latency_access_o[g*5 +: 5]),
      .en_lat     (cfg_en_latency_additional_o[g]),
      .t_cs_max   (cfg_t_cs_max_o[g*32 +: 32]),
      .t_rw_rec   (cfg_t_read_write_recovery_o[g*32 +: 32]),
      .rwds_dly   (cfg_t_rwds_delay_line_o[g*DELAY_BIT_WIDTH +: DELAY_BIT_WIDTH]),
      .t_vari     (cfg_t_variable_latency_check_o[g*4 +: 4]),
      .mem_sel    (cfg_mem_sel_o[g*2 +: 2]),
      .rx_dest    (cfg_rx_dest_o[g*DEST_SIZE +: DEST_SIZE]),
      .tx_dest    (cfg_tx_dest_o[g*DEST_SIZE +: DEST_SIZE])
    );
  end

  // lowest free channel; free is taken from pre-edge state so a reserved id never escapes
  assign free        = ~busy_vec_i & ~reserved;
  assign alloc_valid = |free;

  always_comb begin
    alloc_id = '0;
    for (int i = NB_CH - 1; i >= 0; i--)
      if (free[i]) alloc_id = ID_W'(i);
  end

  always_comb begin
    set_vec = '0;
    rel_vec = '0;
    for (int i = 0; i < NB_CH; i++) begin
      set_vec[i] = rd & (off == 5'h09) & alloc_valid & (alloc_id == ID_W'(i));
      rel_vec[i] = wr & (off == 5'h0C) & (cfg_data_i[ID_W-1:0] == ID_W'(i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reserved <= '0;
      busy_q   <= '0;
    end else begin
      reserved <= (reserved & ~((busy_q & ~busy_vec_i) | rel_vec)) | set_vec;
      busy_q   <= busy_vec_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ST_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n          = state;
    apply            = 1'b0;
    commit_pending_o = 1'b0;
    commit_done_o    = 1'b0;
    case (state)
      ST_IDLE:
        if (wr && off == 5'h0B && cfg_data_i[0]) state_n = ST_WAIT_IDLE;
      ST_WAIT_IDLE: begin
        commit_pending_o = 1'b1;
        if (busy_vec_i == '0) state_n = ST_APPLY;
      end
      ST_APPLY: begin
        commit_pending_o = 1'b1;
        commit_done_o    = 1'b1;
        apply            = 1'b1;
        state_n          = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_data_o = '0;
    case (off)
      5'h09:   cfg_data_o = {alloc_valid, {(31-ID_W){1'b0}}, alloc_id};
      5'h0B:   cfg_data_o = {31'b0, commit_pending_o};
      5'h0D:   cfg_data_o = {{(32-NB_CH){1'b0}}, reserved};
      default:
        for (int b = 0; b < NB_DEV; b++)
          if (bank_ok && bank == BANK_W'(b)) cfg_data_o = bank_rd[b];
    endcase
  end

endmodule
